// File: rtl/qcw_pkg.sv
// Shared types, default parameters and the leg gate-compare helper for the
// phase-shifted full-bridge timing generator.
package qcw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LEAD,
    RUN,
    DRAIN,
    FAULT
  } state_t;

  localparam int unsigned DEF_CNT_W      = 12;
  localparam int unsigned DEF_PHASE_W    = 8;
  localparam int unsigned DEF_DT_W       = 8;
  localparam int unsigned DEF_MIN_LAG    = 6;
  localparam int unsigned DEF_MIN_PERIOD = 16;

  // Compare width wide enough for any supported counter/deadtime width.
  localparam int unsigned CMP_W = 32;

  // Returns {highside, lowside} for counter c, period p, deadtime d.
  function automatic logic [1:0] leg_compare(input logic [CMP_W-1:0] c,
                                             input logic [CMP_W-1:0] p,
                                             input logic [CMP_W-1:0] d);
    logic [CMP_W-1:0] h;
    logic [CMP_W:0]   hd;
    logic [1:0]       res;
    h      = p >> 1;
    hd     = {1'b0, h} + {1'b0, d};
    res[0] = (d < c) && (c < h);
    res[1] = ({1'b0, c} > hd) && (c < p);
    return res;
  endfunction

endpackage

// File: rtl/qcw_bridge_leg.sv
// One half-bridge leg: period counter plus registered complementary gate pair.
module qcw_bridge_leg
  import qcw_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DT_W  = DEF_DT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             advance,
  input  logic             gate,
  input  logic [CNT_W-1:0] period,
  input  logic [DT_W-1:0]  deadtime,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       sw
);

  logic [1:0] cmp_c;

  assign cmp_c = leg_compare(CMP_W'(cnt), CMP_W'(period), CMP_W'(deadtime));

  // Gate outputs follow the counter value of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sw  <= 2'b00;
    end else begin
      sw <= gate ? cmp_c : 2'b00;
      if (restart)
        cnt <= '0;
      else if (advance)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/qcw_phase_bridge.sv
// Phase-shifted full-bridge gate-timing generator: FSM, shadow/active
// registers, lag pipeline and fault synchroniser around two bridge legs.
module qcw_phase_bridge
  import qcw_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PHASE_W    = DEF_PHASE_W,
  parameter int unsigned DT_W       = DEF_DT_W,
  parameter int unsigned MIN_LAG    = DEF_MIN_LAG,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               load,
  input  logic [CNT_W-1:0]   period_value,
  input  logic [PHASE_W-1:0] phase_shift,
  input  logic [DT_W-1:0]    deadtime,
  input  logic               fault,
  output logic               period_done,
  output logic               signal_ref,
  output logic [3:0]         sw,
  output logic               busy,
  output logic               fault_latched
);

  localparam int unsigned PROD_W = CNT_W + PHASE_W;

  state_t state, next_state;

  logic               fault_meta, fault_s;
  logic [CNT_W-1:0]   sh_period, period_a, period_b;
  logic [PHASE_W-1:0] sh_phase, phase_a;
  logic [DT_W-1:0]    sh_dt, dt_a;
  logic [CNT_W-1:0]   lag_raw, lag_active, cnt_a, cnt_b;
  logic [CNT_W-1:0]   lag_lo_c, lag_max_c, lag_clamp_c;
  logic [1:0]         sw_a, sw_b;
  logic               at_wrap_c, at_lag_c, b_restart_c;
  logic               restart_a_c, adv_a_c, gate_a_c;
  logic               restart_b_c, adv_b_c, gate_b_c;
  logic               adopt_c, wrap_c, load_pb_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_meta <= 1'b0;
      fault_s    <= 1'b0;
    end else begin
      fault_meta <= fault;
      fault_s    <= fault_meta;
    end
  end

  // Shadow registers: an out-of-range period rejects the whole load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_period <= CNT_W'(MIN_PERIOD);
      sh_phase  <= '0;
      sh_dt     <= '0;
    end else if (load && (period_value >= CNT_W'(MIN_PERIOD))) begin
      sh_period <= period_value;
      sh_phase  <= phase_shift;
      sh_dt     <= deadtime;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_a <= CNT_W'(MIN_PERIOD);
      period_b <= CNT_W'(MIN_PERIOD);
      phase_a  <= '0;
      dt_a     <= '0;
    end else begin
      if (adopt_c) begin
        period_a <= sh_period;
        phase_a  <= sh_phase;
        dt_a     <= sh_dt;
      end
      if (load_pb_c)
        period_b <= period_a;
    end
  end

  // Two-stage lag: scaled product, then clamp into [MIN_LAG, period_a-1].
  assign lag_max_c   = period_a - CNT_W'(1);
  assign lag_lo_c    = (lag_raw < CNT_W'(MIN_LAG)) ? CNT_W'(MIN_LAG) : lag_raw;
  assign lag_clamp_c = (lag_lo_c > lag_max_c) ? lag_max_c : lag_lo_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      lag_raw    <= '0;
      lag_active <= CNT_W'(MIN_LAG);
    end else begin
      lag_raw    <= CNT_W'((PROD_W'(phase_a) * PROD_W'(period_a)) >> (PHASE_W + 1));
      lag_active <= lag_clamp_c;
    end
  end

  assign at_wrap_c   = (cnt_a == lag_max_c);
  assign at_lag_c    = (cnt_a == lag_active);
  // Restart B one cycle early so cnt_b reads 0 exactly when cnt_a == lag.
  assign b_restart_c = ((cnt_a + CNT_W'(1)) == lag_active);

  always_comb begin
    next_state  = state;
    restart_a_c = 1'b0;
    adv_a_c     = 1'b0;
    gate_a_c    = 1'b0;
    restart_b_c = 1'b0;
    adv_b_c     = 1'b0;
    gate_b_c    = 1'b0;
    adopt_c     = 1'b0;
    wrap_c      = 1'b0;
    load_pb_c   = 1'b0;
    case (state)
      IDLE: begin
        restart_a_c = 1'b1;
        restart_b_c = 1'b1;
        if (enable) next_state = START;
      end
      START: begin
        restart_a_c = 1'b1;
        restart_b_c = 1'b1;
        adopt_c     = 1'b1;
        next_state  = LEAD;
      end
      LEAD: begin
        adv_a_c  = 1'b1;
        gate_a_c = 1'b1;
        if (at_lag_c) begin
          adv_b_c    = 1'b1;
          load_pb_c  = 1'b1;
          next_state = RUN;
        end else begin
          restart_b_c = 1'b1;
        end
      end
      RUN: begin
        gate_a_c = 1'b1;
        gate_b_c = 1'b1;
        if (at_wrap_c) begin
          restart_a_c = 1'b1;
          wrap_c      = 1'b1;
          adopt_c     = 1'b1;
        end else begin
          adv_a_c = 1'b1;
        end
        if (b_restart_c) begin
          restart_b_c = 1'b1;
          load_pb_c   = 1'b1;
        end else begin
          adv_b_c = 1'b1;
        end
        if (!enable) next_state = DRAIN;
      end
      DRAIN: begin
        gate_a_c = 1'b1;
        gate_b_c = 1'b1;
        adv_a_c  = (cnt_a < period_a);
        adv_b_c  = (cnt_b < period_b);
        if ((cnt_a >= period_a) && (cnt_b >= period_b)) next_state = IDLE;
      end
      FAULT: begin
        restart_a_c = 1'b1;
        restart_b_c = 1'b1;
        if (!fault_s && !enable) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Fault wins over everything and blanks the gates this very cycle.
    if (fault_s) begin
      next_state = FAULT;
      gate_a_c   = 1'b0;
      gate_b_c   = 1'b0;
      adopt_c    = 1'b0;
      wrap_c     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      period_done   <= 1'b0;
      signal_ref    <= 1'b0;
      busy          <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= next_state;
      period_done   <= wrap_c;
      signal_ref    <= gate_a_c && (cnt_a < (period_a >> 1));
      busy          <= (next_state != IDLE) && (next_state != FAULT);
      fault_latched <= (next_state == FAULT);
    end
  end

  qcw_bridge_leg #(.CNT_W(CNT_W), .DT_W(DT_W)) u_leg_a (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart_a_c),
    .advance  (adv_a_c),
    .gate     (gate_a_c),
    .period   (period_a),
    .deadtime (dt_a),
    .cnt      (cnt_a),
    .sw       (sw_a)
  );

  qcw_bridge_leg #(.CNT_W(CNT_W), .DT_W(DT_W)) u_leg_b (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart_b_c),
    .advance  (adv_b_c),
    .gate     (gate_b_c),
    .period   (period_b),
    .deadtime (dt_a),
    .cnt      (cnt_b),
    .sw       (sw_b)
  );

  assign sw = {sw_b, sw_a};

endmodule

// File: tb/tb_qcw_phase_bridge.sv
// Directed bench for qcw_phase_bridge: expected timings are queued as each
// step is driven and popped when the corresponding measurement completes.
module tb_qcw_phase_bridge;

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned PHASE_W = 8;
  localparam int unsigned DT_W    = 8;

  logic               clk = 1'b0;
  logic               rst, enable, load, fault;
  logic [CNT_W-1:0]   period_value;
  logic [PHASE_W-1:0] phase_shift;
  logic [DT_W-1:0]    deadtime;
  logic               period_done, signal_ref, busy, fault_latched;
  logic [3:0]         sw;
  logic [7:0]         mon;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  qcw_phase_bridge #(
    .CNT_W(CNT_W), .PHASE_W(PHASE_W), .DT_W(DT_W), .MIN_LAG(6), .MIN_PERIOD(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .load          (load),
    .period_value  (period_value),
    .phase_shift   (phase_shift),
    .deadtime      (deadtime),
    .fault         (fault),
    .period_done   (period_done),
    .signal_ref    (signal_ref),
    .sw            (sw),
    .busy          (busy),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  // bit 0..3 sw, 4 signal_ref, 5 period_done, 6 fault_latched, 7 busy
  assign mon = {busy, fault_latched, period_done, signal_ref, sw};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input int obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wait_level(input int idx, input logic lvl, input int limit, output int n);
    n = 0;
    while (mon[idx] !== lvl) begin
      if (n >= limit) begin
        n = -1;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic wait_rise(input int idx, output int n);
    int a, b;
    wait_level(idx, 1'b0, 2000, a);
    if (a < 0) begin
      n = -1;
      return;
    end
    wait_level(idx, 1'b1, 2000, b);
    n = (b < 0) ? -1 : a + b;
  endtask

  task automatic wait_fall(input int idx, output int n);
    int a, b;
    wait_level(idx, 1'b1, 2000, a);
    if (a < 0) begin
      n = -1;
      return;
    end
    wait_level(idx, 1'b0, 2000, b);
    n = (b < 0) ? -1 : a + b;
  endtask

  task automatic do_load(input int p, input int ph, input int d);
    period_value = CNT_W'(p);
    phase_shift  = PHASE_W'(ph);
    deadtime     = DT_W'(d);
    load         = 1'b1;
    tick();
    load         = 1'b0;
  endtask

  initial begin
    int n, c0, c1, c2;
    rst = 1'b1; enable = 1'b0; load = 1'b0; fault = 1'b0;
    period_value = '0; phase_shift = '0; deadtime = '0;
    tick(); tick();
    expect_val("reset_outputs", 0);
    chk(int'(mon));
    rst = 1'b0;
    tick();

    // Period 100, phase 0, deadtime 5: lag clamps to 6.
    do_load(100, 0, 5);
    expect_val("sw1_first_edge", 9);
    enable = 1'b1;
    wait_rise(0, n); chk(n);
    expect_val("sw1_width", 44);
    wait_fall(0, n); chk(n);
    expect_val("sw2_after_sw1", 6);
    wait_rise(1, n); chk(n);
    expect_val("sw2_width", 44);
    wait_fall(1, n); chk(n);
    wait_rise(5, n);
    expect_val("period_done_100", 100);
    wait_rise(5, n); chk(n);
    wait_rise(0, n);
    expect_val("lag_phase0", 6);
    wait_rise(2, n); chk(n);
    wait_rise(4, n);
    expect_val("signal_ref_high", 50);
    wait_fall(4, n); chk(n);

    // Period 200, phase 128 -> lag 50; later phase 255 -> lag 99.
    do_load(200, 128, 5);
    wait_rise(5, n); wait_rise(5, n);
    expect_val("period_done_200", 200);
    wait_rise(5, n); chk(n);
    wait_rise(0, n);
    expect_val("lag_phase128", 50);
    wait_rise(2, n); chk(n);
    do_load(200, 255, 5);
    wait_rise(5, n); wait_rise(5, n); wait_rise(5, n);
    wait_rise(0, n);
    expect_val("lag_phase255", 99);
    wait_rise(2, n); chk(n);

    // Deadtime beyond half period: no gates, reference still 50/50.
    do_load(100, 0, 60);
    wait_rise(5, n); wait_rise(5, n);
    c0 = 0; c1 = 0;
    repeat (100) begin
      if (sw !== 4'b0000) c0++;
      if (signal_ref === 1'b1) c1++;
      tick();
    end
    expect_val("bigdt_sw_active", 0);
    chk(c0);
    expect_val("bigdt_ref_high", 50);
    chk(c1);

    // Drop enable mid-period: both legs finish, no period_done while draining.
    do_load(100, 0, 5);
    wait_rise(5, n); wait_rise(5, n);
    wait_rise(5, n);
    repeat (30) tick();
    enable = 1'b0;
    c0 = 0; c1 = 0; c2 = 0; n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (period_done === 1'b1) c0++;
      if (sw[1] === 1'b1) c1++;
      if (sw[3] === 1'b1) c2++;
      tick();
      n++;
    end
    expect_val("drain_busy_end", 0);
    chk(int'(busy));
    expect_val("drain_period_done", 0);
    chk(c0);
    expect_val("drain_sw2_cycles", 44);
    chk(c1);
    expect_val("drain_sw4_cycles", 44);
    chk(c2);
    expect_val("drain_idle_sw", 0);
    chk(int'(sw));

    // Fault during RUN: gates off in 3 cycles, latched until enable drops.
    enable = 1'b1;
    wait_rise(0, n);
    fault = 1'b1;
    n = 0;
    while (!(sw === 4'b0000 && fault_latched === 1'b1) && n < 10) begin
      tick();
      n++;
    end
    expect_val("fault_response", 3);
    chk(n);
    expect_val("fault_busy", 0);
    chk(int'(busy));
    fault = 1'b0;
    c0 = 0;
    repeat (10) begin
      tick();
      if (sw !== 4'b0000) c0++;
    end
    expect_val("fault_hold_latched", 1);
    chk(int'(fault_latched));
    expect_val("fault_hold_sw", 0);
    chk(c0);
    enable = 1'b0;
    repeat (5) tick();
    expect_val("fault_exit", 0);
    chk(int'(mon));

    // Short period load is rejected: shadow keeps period 100.
    do_load(10, 0, 5);
    enable = 1'b1;
    wait_rise(5, n);
    expect_val("short_load_ignored", 100);
    wait_rise(5, n); chk(n);

    // Reset mid-RUN clears outputs and returns the shadow to MIN_PERIOD.
    wait_rise(0, n);
    rst = 1'b1;
    tick();
    expect_val("rst_outputs", 0);
    chk(int'(mon));
    rst = 1'b0;
    wait_rise(5, n);
    expect_val("rst_shadow_period", 16);
    wait_rise(5, n); chk(n);

    enable = 1'b0;
    wait_level(7, 1'b0, 500, n);
    expect_val("final_idle", 0);
    chk(int'(busy));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
